// File: rtl/d7seg_scan_if.sv
// d7seg_scan_if: display-scanner bus; master drives scan controls and data, slave drives the panel pins.
interface d7seg_scan_if #(
  parameter int NDIG = 4,
  parameter int BW = 3
);
  logic ena;
  logic [4*NDIG-1:0] data;
  logic [NDIG-1:0] dp;
  logic [BW-1:0] bright;
  logic [NDIG-1:0] an;
  logic [6:0] seg;
  logic dp_n;
  logic frame_tc;
  modport master (output ena, data, dp, bright, input an, seg, dp_n, frame_tc);
  modport slave (input ena, data, dp, bright, output an, seg, dp_n, frame_tc);
endinterface

// File: rtl/d7seg_scan.sv
// d7seg_scan: multiplexed 7-segment scanner with PWM brightness and frame-synchronous shadowing.
// Define D7SEG_LZB_EN to enable leading-zero blanking.
module d7seg_scan #(
  parameter int NDIG = 4,
  parameter int DIV = 5000,
  parameter int BW = 3
) (
  input logic clk,
  input logic rst_n,
  d7seg_scan_if.slave bus
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NDIG - 1);
  localparam logic [15:0][6:0] HEX = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] pwm_q, pwm_d;
  logic [4*NDIG-1:0] data_s_q, data_s_d;
  logic [NDIG-1:0] dp_s_q, dp_s_d;
  logic [BW-1:0] bright_s_q, bright_s_d;
  logic [NDIG-1:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic dpn_q, dpn_d;
  logic ftc_q, ftc_d;
  logic tick, wrap, lit;
  logic [3:0] nib;
  logic [NDIG-1:0] blank;
`ifdef D7SEG_LZB_EN
  logic z;
  // A digit blanks only while it and every higher digit are zero with no decimal point.
  always_comb begin
    blank = '0;
    z = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      z = z && data_s_q[4*k +: 4] == 4'd0 && !dp_s_q[k];
      blank[k] = z;
    end
  end
`else
  assign blank = '0;
`endif
  always_comb begin
    tick = bus.ena && presc_q == PMAX;
    wrap = tick && idx_q == IMAX;
    presc_d = !bus.ena ? presc_q : tick ? '0 : presc_q + PW'(1);
    idx_d = !tick ? idx_q : wrap ? '0 : idx_q + IW'(1);
    pwm_d = bus.ena ? pwm_q + BW'(1) : pwm_q;
    data_s_d = wrap ? bus.data : data_s_q;
    dp_s_d = wrap ? bus.dp : dp_s_q;
    bright_s_d = wrap ? bus.bright : bright_s_q;
    ftc_d = wrap;
    nib = data_s_q[4*idx_q +: 4];
    lit = bus.ena && pwm_q <= bright_s_q && !blank[idx_q];
    an_d = lit ? ~(NDIG'(1) << idx_q) : '1;
    seg_d = lit ? HEX[nib] : '1;
    dpn_d = lit ? !dp_s_q[idx_q] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q <= '0;
      pwm_q <= '0;
      data_s_q <= '0;
      dp_s_q <= '0;
      bright_s_q <= '0;
      an_q <= '1;
      seg_q <= '1;
      dpn_q <= 1'b1;
      ftc_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q <= idx_d;
      pwm_q <= pwm_d;
      data_s_q <= data_s_d;
      dp_s_q <= dp_s_d;
      bright_s_q <= bright_s_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dpn_q <= dpn_d;
      ftc_q <= ftc_d;
    end
  end
  assign bus.an = an_q;
  assign bus.seg = seg_q;
  assign bus.dp_n = dpn_q;
  assign bus.frame_tc = ftc_q;
endmodule

// File: tb/tb_d7seg_scan.sv
// tb_d7seg_scan: timestamped scoreboard bench for d7seg_scan (NDIG=4, DIV=4, BW=3); honours D7SEG_LZB_EN.
module tb_d7seg_scan;
  localparam int B = 3;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, SA = 7'b0001000, SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SX = 7'b1111111;
  typedef struct {
    int stamp;
    logic [3:0] an;
    logic [6:0] seg;
    logic dpn;
    logic ftc;
    string name;
  } exp_t;
  exp_t q[$];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit async_chk = 1'b0;
  bit done = 1'b0;
  d7seg_scan_if #(.NDIG(4), .BW(3)) bus ();
  d7seg_scan #(.NDIG(4), .DIV(4), .BW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic push(input int s, input logic [3:0] an, input logic [6:0] sg, input logic dpn, input logic ftc, input string nm);
    q.push_back('{s, an, sg, dpn, ftc, nm});
  endtask
  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic check(input int tag);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].stamp == tag) begin
        n_chk++;
        if ({bus.an, bus.seg, bus.dp_n, bus.frame_tc} !== {q[i].an, q[i].seg, q[i].dpn, q[i].ftc}) begin
          n_fail++;
          $display("FAIL %s @%0d: got an=%b seg=%b dp_n=%b ftc=%b, expected an=%b seg=%b dp_n=%b ftc=%b",
                   q[i].name, tag, bus.an, bus.seg, bus.dp_n, bus.frame_tc, q[i].an, q[i].seg, q[i].dpn, q[i].ftc);
        end
        q.delete(i);
      end
    end
  endtask
  initial begin
    while (!done) begin
      @(negedge clk or negedge rst_n);
      #1 check(async_chk ? -1 : cyc);
    end
    foreach (q[i]) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: never sampled at stamp %0d", q[i].name, q[i].stamp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    bus.ena = 1'b0;
    bus.data = '0;
    bus.dp = '0;
    bus.bright = '0;
    push(2, 4'b1111, SX, 1, 0, "reset_state");
    at(B);
    rst_n = 1'b1;
    bus.ena = 1'b1;
    bus.data = 16'h1234;
    bus.dp = 4'b0010;
    bus.bright = 3'd7;
    push(B + 1, 4'b1110, S0, 1, 0, "f1_zero_shadow");
    push(B + 2, 4'b1111, SX, 1, 0, "f1_bright0_off");
    push(B + 9, 4'b1011, S0, 1, 0, "f1_dig2_pwm0");
    push(B + 15, 4'b1111, SX, 1, 0, "f1_pre_wrap");
    push(B + 16, 4'b1111, SX, 1, 1, "f1_frame_tc");
    push(B + 17, 4'b1110, S4, 1, 0, "d0_first");
    push(B + 20, 4'b1110, S4, 1, 0, "d0_last");
    push(B + 21, 4'b1101, S3, 0, 0, "d1_dp");
    at(B + 22);
    bus.data = 16'hABCD;
    bus.dp = 4'b0000;
    push(B + 25, 4'b1011, S2, 1, 0, "d2_unchanged");
    push(B + 29, 4'b0111, S1, 1, 0, "d3_unchanged");
    push(B + 32, 4'b0111, S1, 1, 1, "f2_frame_tc");
    push(B + 33, 4'b1110, SD, 1, 0, "new_d0_D");
    push(B + 37, 4'b1101, SC, 1, 0, "new_d1_C");
    push(B + 41, 4'b1011, SB, 1, 0, "new_d2_b");
    push(B + 45, 4'b0111, SA, 1, 0, "new_d3_A");
    at(B + 34);
    bus.bright = 3'd1;
    push(B + 48, 4'b0111, SA, 1, 1, "f3_frame_tc");
    push(B + 49, 4'b1110, SD, 1, 0, "pwm1_on0");
    push(B + 50, 4'b1110, SD, 1, 0, "pwm1_on1");
    push(B + 51, 4'b1111, SX, 1, 0, "pwm1_off2");
    push(B + 57, 4'b1011, SB, 1, 0, "pwm1_on8");
    push(B + 58, 4'b1011, SB, 1, 0, "pwm1_on9");
    push(B + 59, 4'b1111, SX, 1, 0, "pwm1_off10");
    push(B + 61, 4'b1111, SX, 1, 0, "pwm1_off12");
    at(B + 50);
    bus.bright = 3'd7;
    push(B + 64, 4'b1111, SX, 1, 1, "f4_frame_tc");
    push(B + 65, 4'b1110, SD, 1, 0, "bright7_a");
    push(B + 66, 4'b1110, SD, 1, 0, "bright7_b");
    push(B + 67, 4'b1111, SX, 1, 0, "ena_low_blank");
    push(B + 76, 4'b1111, SX, 1, 0, "ena_low_hold");
    push(B + 77, 4'b1110, SD, 1, 0, "resume_d0");
    push(B + 78, 4'b1110, SD, 1, 0, "resume_d0_end");
    push(B + 79, 4'b1101, SC, 1, 0, "resume_d1");
    push(B + 80, 4'b1101, SC, 1, 0, "no_early_wrap");
    push(B + 89, 4'b0111, SA, 1, 0, "pre_shift_wrap");
    push(B + 90, 4'b0111, SA, 1, 1, "shifted_frame_tc");
    push(B + 91, 4'b1110, SD, 1, 0, "post_shift_wrap");
    at(B + 66);
    bus.ena = 1'b0;
    at(B + 76);
    bus.ena = 1'b1;
    push(B + 95, 4'b1101, SC, 1, 0, "pre_reset");
    push(-1, 4'b1111, SX, 1, 0, "async_reset");
    push(B + 97, 4'b1111, SX, 1, 0, "in_reset");
    push(B + 99, 4'b1110, S0, 1, 0, "rst_first_d0");
    push(B + 100, 4'b1111, SX, 1, 0, "rst_bright_cleared");
    push(B + 107, 4'b1011, S0, 1, 0, "rst_d2_zero");
    push(B + 113, 4'b1111, SX, 1, 0, "rst_pre_wrap");
    push(B + 114, 4'b1111, SX, 1, 1, "rst_frame_tc");
    push(B + 115, 4'b1110, S0, 1, 0, "z50_d0");
    push(B + 119, 4'b1101, S5, 1, 0, "z50_d1");
    push(B + 131, 4'b1110, S0, 1, 0, "z00_d0");
`ifdef D7SEG_LZB_EN
    push(B + 123, 4'b1111, SX, 1, 0, "z50_d2_blank");
    push(B + 127, 4'b1111, SX, 1, 0, "z50_d3_blank");
    push(B + 135, 4'b1111, SX, 1, 0, "z00_d1_blank");
    push(B + 143, 4'b1111, SX, 1, 0, "z00_d3_blank");
`else
    push(B + 123, 4'b1011, S0, 1, 0, "z50_d2_zero");
    push(B + 127, 4'b0111, S0, 1, 0, "z50_d3_zero");
    push(B + 135, 4'b1101, S0, 1, 0, "z00_d1_zero");
    push(B + 143, 4'b0111, S0, 1, 0, "z00_d3_zero");
`endif
    at(B + 95);
    #2 async_chk = 1'b1;
    #1 rst_n = 1'b0;
    #2 async_chk = 1'b0;
    bus.data = 16'h0050;
    at(B + 98);
    rst_n = 1'b1;
    at(B + 116);
    bus.data = 16'h0000;
    at(B + 150);
    done = 1'b1;
  end
endmodule
